// File: rtl/iq_upconverter.sv
`default_nettype none
// ============================================================================
//  Module      : iq_upconverter
//  Description : Takes I/Q symbols (16-bit offset binary) from the QAM mapper
//                and holds each one for SPS samples. Each sample is mixed with
//                a quadrature NCO built on a quarter-wave sine LUT. The output
//                y = I*cos - Q*sin is rounded and saturated to OUT_W signed
//                bits for the DAC. The sample pipeline is three stages deep
//                and is frozen by en.
//  Options     : IQ_UPCONV_HOLD_EN - when a symbol is missing at a symbol
//                boundary, keep repeating the last held symbol. The carrier
//                stays on instead of the block returning to idle. underrun is
//                flagged either way.
//  Revision    : 1.0  initial release
// ============================================================================
module iq_upconverter #(
    parameter int SPS     = 8,
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 6,
    parameter int OUT_W   = 16
) (
    input  logic               dclk,
    input  logic               rst,
    input  logic               en,
    input  logic [15:0]        inphase,
    input  logic [15:0]        quadrature,
    input  logic               sym_valid,
    output logic               sym_ready,
    input  logic [PHASE_W-1:0] fcw,
    output logic [OUT_W-1:0]   rf_out,
    output logic               rf_valid,
    output logic               underrun
);

    localparam int                    c_cnt_w    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(SPS - 1);
    localparam int                    c_lut_n    = 2 ** LUT_AW;
    localparam longint                c_pi_q30   = 64'sd3373259426;
    localparam logic signed [32:0]    c_round    = 33'sd16384;
    localparam logic signed [32:0]    c_y_max    = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
    localparam logic signed [32:0]    c_y_min    = -(33'sd1 <<< (OUT_W - 1));

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Quarter-wave table entry k = round(32767 * sin(pi/2 * (k+0.5) / 2^LUT_AW)).
    // This is evaluated at elaboration time with a Q30 Taylor series. Integer
    // arithmetic keeps it portable across tools that reject real math in
    // constant functions. Eight terms give far more precision than the
    // 15-bit result needs.
    // ------------------------------------------------------------------------
    function automatic longint f_lut_entry(input int k);
        longint x;
        longint x2;
        longint term;
        longint acc;
        x    = (c_pi_q30 * longint'(2 * k + 1)) >>> (LUT_AW + 2);
        x2   = (x * x) >>> 30;
        term = x;
        acc  = x;
        for (int n = 1; n <= 8; n++) begin
            term = (-((term * x2) >>> 30)) / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return (longint'(32767) * acc + (longint'(1) <<< 29)) >>> 30;
    endfunction

    logic [14:0] w_lut [c_lut_n];

    for (genvar k = 0; k < c_lut_n; k++) begin : g_lut
        localparam longint c_entry = f_lut_entry(k);
        assign w_lut[k] = c_entry[14:0];
    end

    // ------------------------------------------------------------------------
    // Symbol hold, NCO phase and sequencing state
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [PHASE_W-1:0]   r_phase;
    logic signed [15:0]   r_i;
    logic signed [15:0]   r_q;
    logic                 r_underrun;

    logic signed [15:0]   w_sym_i;
    logic signed [15:0]   w_sym_q;
    logic                 w_at_boundary;
    logic                 w_issue;

    // Offset binary to two's complement: flipping the MSB recentres 0x8000 on zero
    assign w_sym_i = $signed({~inphase[15], inphase[14:0]});
    assign w_sym_q = $signed({~quadrature[15], quadrature[14:0]});

    assign w_at_boundary = (r_cnt == c_cnt_last);
    assign w_issue       = (r_state == ST_RUN);

    // A new symbol is taken while idle, or on the last sample of the current
    // symbol. Taking it there makes back-to-back symbols seamless.
    assign sym_ready = en & ((r_state == ST_IDLE) | ((r_state == ST_RUN) & w_at_boundary));
    assign underrun  = r_underrun;

    // Symbol FSM: accept, count samples, advance the NCO, detect underrun
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_phase    <= '0;
            r_i        <= '0;
            r_q        <= '0;
            r_underrun <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (sym_valid) begin
                        r_i     <= w_sym_i;
                        r_q     <= w_sym_q;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The sample issued this cycle uses the pre-increment phase
                    r_phase <= r_phase + fcw;
                    if (w_at_boundary) begin
                        r_cnt <= '0;
                        if (sym_valid) begin
                            r_i <= w_sym_i;
                            r_q <= w_sym_q;
                        end else begin
                            r_underrun <= 1'b1;
`ifdef IQ_UPCONV_HOLD_EN
                            // Stay in RUN: the held symbol repeats for another SPS samples
                            r_state <= ST_RUN;
`else
                            r_state <= ST_IDLE;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // NCO lookup. The top two phase bits select the quadrant and the next
    // LUT_AW bits address the quarter-wave table. Odd quadrants read the
    // table mirrored and the upper half-wave is negated. Cosine is sine one
    // quadrant ahead, so only the quadrant number changes.
    // ------------------------------------------------------------------------
    logic [1:0]          w_quad;
    logic [1:0]          w_cos_quad;
    logic [LUT_AW-1:0]   w_addr;
    logic [LUT_AW-1:0]   w_sin_idx;
    logic [LUT_AW-1:0]   w_cos_idx;
    logic signed [15:0]  w_sin_mag;
    logic signed [15:0]  w_cos_mag;
    logic signed [15:0]  w_sin;
    logic signed [15:0]  w_cos;

    // Quadrant folding of the quarter-wave table into full sin/cos
    always_comb begin
        w_quad     = r_phase[PHASE_W-1 -: 2];
        w_addr     = r_phase[PHASE_W-3 -: LUT_AW];
        w_cos_quad = w_quad + 2'd1;
        w_sin_idx  = w_quad[0]     ? ~w_addr : w_addr;
        w_cos_idx  = w_cos_quad[0] ? ~w_addr : w_addr;
        w_sin_mag  = $signed({1'b0, w_lut[w_sin_idx]});
        w_cos_mag  = $signed({1'b0, w_lut[w_cos_idx]});
        w_sin      = w_quad[1]     ? -w_sin_mag : w_sin_mag;
        w_cos      = w_cos_quad[1] ? -w_cos_mag : w_cos_mag;
    end

    // ------------------------------------------------------------------------
    // Mixer pipeline: S1 table output, S2 products, S3 difference + round +
    // saturate. The valid bit travels alongside the data.
    // ------------------------------------------------------------------------
    logic                 r_v1;
    logic signed [15:0]   r_sin1;
    logic signed [15:0]   r_cos1;
    logic signed [15:0]   r_i1;
    logic signed [15:0]   r_q1;
    logic                 r_v2;
    logic signed [31:0]   r_pi2;
    logic signed [31:0]   r_pq2;
    logic                 r_v3;
    logic [OUT_W-1:0]     r_y3;

    logic signed [32:0]   w_sum;
    logic signed [32:0]   w_rnd;
    logic signed [32:0]   w_shift;
    logic [OUT_W-1:0]     w_sat;

    // Round half up, then clamp to the signed OUT_W range
    always_comb begin
        w_sum   = $signed({r_pi2[31], r_pi2}) - $signed({r_pq2[31], r_pq2});
        w_rnd   = w_sum + c_round;
        w_shift = w_rnd >>> 15;
        if (w_shift > c_y_max) begin
            w_sat = c_y_max[OUT_W-1:0];
        end else if (w_shift < c_y_min) begin
            w_sat = c_y_min[OUT_W-1:0];
        end else begin
            w_sat = w_shift[OUT_W-1:0];
        end
    end

    // Three-stage mixer pipeline, frozen together with the FSM when en is low
    always_ff @(posedge dclk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_sin1 <= '0;
            r_cos1 <= '0;
            r_i1   <= '0;
            r_q1   <= '0;
            r_v2   <= 1'b0;
            r_pi2  <= '0;
            r_pq2  <= '0;
            r_v3   <= 1'b0;
            r_y3   <= '0;
        end else if (en) begin
            r_v1   <= w_issue;
            r_sin1 <= w_sin;
            r_cos1 <= w_cos;
            r_i1   <= r_i;
            r_q1   <= r_q;
            r_v2   <= r_v1;
            r_pi2  <= r_i1 * r_cos1;
            r_pq2  <= r_q1 * r_sin1;
            r_v3   <= r_v2;
            r_y3   <= w_sat;
        end
    end

    // A frozen block presents no sample, and the bus reads zero between samples
    assign rf_valid = en & r_v3;
    assign rf_out   = rf_valid ? r_y3 : '0;

endmodule
`default_nettype wire
